// File: rtl/mdu_iter_pkg.sv
// Shared decode/execute types for the iterative multiply/divide unit.
// Other pipe stages use is_mdu_op() to steer ops and detect MDU hazards.
package mdu_iter_pkg;
    localparam int MDU_XLEN      = 64;
    localparam int MDU_STEP_BITS = 1;
    localparam int MDU_ITERS     = MDU_XLEN / MDU_STEP_BITS;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_SRA, OP_LD, OP_ST, OP_BR,
        OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
        OP_MOD, OP_MODU, OP_MODW, OP_MODUW
    } decode_op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

    function automatic logic is_mdu_op(input decode_op_t op);
        return op inside {OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
                          OP_MOD, OP_MODU, OP_MODW, OP_MODUW};
    endfunction
endpackage

// File: rtl/mdu_iter_if.sv
// Operand/result handshake between execute and the iterative MDU.
// master = execute stage driving ops; slave = the MDU.
interface mdu_iter_if;
    import mdu_iter_pkg::*;

    logic        in_valid;
    logic        in_ready;
    decode_op_t  op;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output in_valid, op, srca, srcb, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, srca, srcb, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu_divstep.sv
// Combinational restoring-division step(s) on a {rem,quot} shift register, MSB first.
// No state; one call retires STEP_BITS quotient bits.
module mdu_divstep #(
    parameter int XLEN      = 64,
    parameter int STEP_BITS = 1
) (
    input  logic [2*XLEN-1:0] rq,
    input  logic [XLEN-1:0]   dvsr,
    output logic [2*XLEN-1:0] rq_nxt
);
    logic [XLEN:0] r2;
    logic [XLEN:0] diff;

    // rem < dvsr always holds, so the shifted remainder fits in XLEN+1 bits
    // and diff's top bit is a clean borrow flag.
    always_comb begin
        rq_nxt = rq;
        r2     = '0;
        diff   = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            r2   = rq_nxt[2*XLEN-1:XLEN-1];
            diff = r2 - {1'b0, dvsr};
            if (!diff[XLEN])
                rq_nxt = {diff[XLEN-1:0], rq_nxt[XLEN-2:0], 1'b1};
            else
                rq_nxt = {r2[XLEN-1:0], rq_nxt[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide: ITERS+1 cycles per op, 1 cycle for div-by-zero/overflow.
// Accepts only in IDLE; holds result in DONE until out_ready.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int STEP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    mdu_iter_if.slave  io
);
    localparam int ITERS = XLEN / STEP_BITS;
    localparam int CW    = $clog2(ITERS);
    localparam int H     = XLEN / 2;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MUL  = MUL;
    localparam logic [1:0] ST_DIV  = DIV;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] rq;      // div: {rem,quot}; mul: {acc,multiplier}
    logic [XLEN-1:0]   dvsr;    // div: divisor magnitude; mul: shifted multiplicand
    logic              neg_q, neg_r, is_w, is_rem;
    logic [XLEN-1:0]   result;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w);
        return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
    endfunction

    logic            op_mul, op_w, op_uw, op_sgn, op_rem;
    logic [XLEN-1:0] a_x, b_x, a_mag, b_mag, spec_val;
    logic            a_neg, b_neg, div0, ovf, special;

    assign op_mul = io.op inside {OP_MUL, OP_MULW};
    assign op_w   = io.op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_MODW, OP_MODUW};
    assign op_uw  = io.op inside {OP_DIVUW, OP_MODUW};
    assign op_sgn = io.op inside {OP_DIV, OP_DIVW, OP_MOD, OP_MODW};
    assign op_rem = io.op inside {OP_MOD, OP_MODU, OP_MODW, OP_MODUW};

    assign a_x = !op_w ? io.srca : op_uw ? {{H{1'b0}}, io.srca[H-1:0]}
                                         : {{H{io.srca[H-1]}}, io.srca[H-1:0]};
    assign b_x = !op_w ? io.srcb : op_uw ? {{H{1'b0}}, io.srcb[H-1:0]}
                                         : {{H{io.srcb[H-1]}}, io.srcb[H-1:0]};

    assign a_neg = op_sgn & a_x[XLEN-1];
    assign b_neg = op_sgn & b_x[XLEN-1];
    assign a_mag = a_neg ? -a_x : a_x;
    assign b_mag = b_neg ? -b_x : b_x;

    assign div0 = (b_x == '0);
    assign ovf  = op_sgn && (op_w ? (a_x[H-1:0] == {1'b1, {(H-1){1'b0}}} && b_x[H-1:0] == '1)
                                  : (a_x == {1'b1, {(XLEN-1){1'b0}}} && b_x == '1));
    assign special  = !op_mul && (div0 || ovf);
    assign spec_val = op_rem ? (div0 ? a_x : '0) : (div0 ? '1 : a_x);

    logic [XLEN-1:0] acc_n, mp_n, mc_n;
    always_comb begin
        acc_n = rq[2*XLEN-1:XLEN];
        mp_n  = rq[XLEN-1:0];
        mc_n  = dvsr;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mp_n[0])
                acc_n = acc_n + mc_n;
            mc_n = mc_n << 1;
            mp_n = mp_n >> 1;
        end
    end

    logic [2*XLEN-1:0] rq_div;
    mdu_divstep #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_divstep (
        .rq     (rq),
        .dvsr   (dvsr),
        .rq_nxt (rq_div)
    );

    logic [XLEN-1:0] q_fin, r_fin, div_res;
    assign q_fin   = rq_div[XLEN-1:0];
    assign r_fin   = rq_div[2*XLEN-1:XLEN];
    assign div_res = is_rem ? (neg_r ? -r_fin : r_fin) : (neg_q ? -q_fin : q_fin);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rq     <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_w   <= 1'b0;
            is_rem <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (io.in_valid) begin
                    cnt    <= CW'(ITERS - 1);
                    is_w   <= op_w;
                    is_rem <= op_rem;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    if (op_mul) begin
                        rq    <= {{XLEN{1'b0}}, b_x};
                        dvsr  <= a_x;
                        state <= ST_MUL;
                    end else if (special) begin
                        result <= wext(spec_val, op_w);
                        state  <= ST_DONE;
                    end else begin
                        rq    <= {{XLEN{1'b0}}, a_mag};
                        dvsr  <= b_mag;
                        state <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    rq   <= {acc_n, mp_n};
                    dvsr <= mc_n;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= wext(acc_n, is_w);
                        state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    rq  <= rq_div;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= wext(div_res, is_w);
                        state  <= ST_DONE;
                    end
                end
                default: if (io.out_ready) state <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == ST_IDLE);
    assign io.out_valid = (state == ST_DONE);
    assign io.busy      = (state != ST_IDLE);
    assign io.result    = result;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed vector bench for mdu_iter: result values, accept-to-valid latency and
// handshake/flush/reset corner sequences.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    mdu_iter_if io();

    mdu_iter dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        decode_op_t  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Presents one op, counts posedges from the accept edge (inclusive) to out_valid, then consumes.
    task automatic run_op(input decode_op_t op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        io.op = op; io.srca = a; io.srcb = b; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0; io.srca = ~a; io.srcb = ~b; io.op = OP_MULW;
        lat = 1;
        while (!io.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = io.result;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!io.out_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_out_valid", 64'(io.out_valid), 64'd1);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          seen;

        io.in_valid = 1'b0; io.out_ready = 1'b0; io.op = OP_NOP;
        io.srca = '0; io.srcb = '0;

        vt[0]  = '{OP_MUL,   64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vt[1]  = '{OP_DIVU,  64'd100,                64'd7,                   64'd14,                  65};
        vt[2]  = '{OP_MODU,  64'd100,                64'd7,                   64'd2,                   65};
        vt[3]  = '{OP_MOD,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 65};
        vt[4]  = '{OP_DIV,   64'd5,                  64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[5]  = '{OP_MODUW, 64'h1_0000_0005,        64'd0,                   64'd5,                   1};
        vt[6]  = '{OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vt[7]  = '{OP_MOD,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                 1};
        vt[8]  = '{OP_DIVW,  64'h8000_0000,          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vt[9]  = '{OP_MULW,  64'h7FFF_FFFF,          64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 65};
        vt[10] = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  64'hFFFF_FFFF_FFFF_FFF2, 65};
        vt[11] = '{OP_DIVW,  64'hDEAD_BEEF_FFFF_FF9C, 64'h1234_5678_0000_0007, 64'hFFFF_FFFF_FFFF_FFF2, 65};
        vt[12] = '{OP_MODW,  64'hAAAA_AAAA_0000_0064, 64'h5555_5555_FFFF_FFF9, 64'd2,                 65};
        vt[13] = '{OP_DIVUW, 64'hABCD_0000_FFFF_FFFF, 64'hFFFF_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vt[14] = '{OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'h7FFF_FFFF_FFFF_FFFF, 65};
        vt[15] = '{OP_MUL,   64'h1234_5678,          64'h10,                  64'h1_2345_6780,         65};
        vt[16] = '{OP_DIVUW, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[17] = '{OP_MODW,  64'h1111_1111_8000_0000, 64'h2222_2222_FFFF_FFFF, 64'd0,                 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(io.in_ready), 64'd1);
        check("rst_out_valid", 64'(io.out_valid), 64'd0);
        check("rst_busy", 64'(io.busy), 64'd0);
        check("rst_result", io.result, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vt[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
        end

        // Backpressure: result held in DONE, and the pending op waits until IDLE.
        io.op = OP_DIVU; io.srca = 64'd100; io.srcb = 64'd7; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.srca = 64'd9; io.srcb = 64'd2;
        wait_valid(200);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_result", k), io.result, 64'd14);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(io.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check("bp_no_accept_in_done", 64'(io.busy), 64'd0);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        check("bp_next_accepted", 64'(io.busy), 64'd1);
        wait_valid(200);
        check("bp_next_result", io.result, 64'd4);
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;

        // Flush partway through a divide; the simultaneous in_valid must be dropped.
        io.op = OP_DIV; io.srca = 64'd1000; io.srcb = 64'd3; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        flush = 1'b1; io.in_valid = 1'b1; io.op = OP_DIVU; io.srca = 64'd9; io.srcb = 64'd2;
        @(posedge clk); #1;
        flush = 1'b0; io.in_valid = 1'b0;
        check("flush_busy", 64'(io.busy), 64'd0);
        check("flush_in_ready", 64'(io.in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            if (io.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_out_valid", 64'(seen), 64'd0);
        run_op(OP_DIVU, 64'd9, 64'd2, res, lat);
        check("post_flush_divu", res, 64'd4);

        // Reset in the middle of a multiply.
        io.op = OP_MUL; io.srca = 64'd3; io.srcb = 64'd5; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(io.in_ready), 64'd1);
        check("midrst_out_valid", 64'(io.out_valid), 64'd0);
        check("midrst_busy", 64'(io.busy), 64'd0);
        check("midrst_result", io.result, 64'd0);
        reset = 1'b0;
        run_op(OP_MUL, 64'd3, 64'd5, res, lat);
        check("post_rst_mul", res, 64'd15);
        check("post_rst_latency", 64'(lat), 64'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
